mc_lifo: RTL and testbench



---
 rtl/mc_lifo_pkg.sv | 30 +++
 rtl/mc_lifo_ram.sv | 32 +++
 rtl/mc_lifo.sv | 175 +++++++++++++++++
 tb/tb_mc_lifo.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_lifo_pkg.sv
// mc_lifo shared types and helpers.
// Flag math is common to every channel.
package mc_lifo_pkg;

  typedef struct packed {
    logic empty;
    logic aempty;
    logic afull;
    logic full;
  } flags_t;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic flags_t calc_flags(
    input int unsigned used,
    input int unsigned depth,
    input int unsigned af,
    input int unsigned ae
  );
    flags_t f;
    f.empty  = (used == 0);
    f.aempty = (used <= ae);
    f.afull  = (used >= af);
    f.full   = (used == depth);
    return f;
  endfunction

endpackage

// File: rtl/mc_lifo_ram.sv
// Simple dual-port RAM, one write port and
// one registered read port. Contents never reset.
module mc_lifo_ram #(
  parameter int DWIDTH = 16,
  parameter int RAW    = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [RAW-1:0]    waddr_i,
  input  logic [DWIDTH-1:0] wdata_i,
  input  logic              re_i,
  input  logic [RAW-1:0]    raddr_i,
  output logic [DWIDTH-1:0] rdata_o
);

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [DWIDTH-1:0] rdata_q;

  // write port
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // registered read port, holds between reads
  always_ff @(posedge clk_i) begin
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mc_lifo.sv
// Multi-channel LIFO: per-channel stack pointers
// over one shared RAM, with push->pop bypass.
module mc_lifo
  import mc_lifo_pkg::*;
#(
  parameter int DWIDTH       = 16,
  parameter int AWIDTH       = 8,
  parameter int CHANNELS     = 4,
  parameter int ALMOST_FULL  = 2,
  parameter int ALMOST_EMPTY = 2,
  localparam int CH_W        = ch_w(CHANNELS)
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            wrreq_i,
  input  logic [CH_W-1:0]                 wr_ch_i,
  input  logic [DWIDTH-1:0]               data_i,
  input  logic                            rdreq_i,
  input  logic [CH_W-1:0]                 rd_ch_i,
  input  logic                            clear_i,
  input  logic [CH_W-1:0]                 clear_ch_i,
  output logic [DWIDTH-1:0]               q_o,
  output logic                            q_valid_o,
  output logic [CH_W-1:0]                 q_ch_o,
  output logic [CHANNELS-1:0]             empty_o,
  output logic [CHANNELS-1:0]             almost_empty_o,
  output logic [CHANNELS-1:0]             almost_full_o,
  output logic [CHANNELS-1:0]             full_o,
  output logic [CHANNELS*(AWIDTH+1)-1:0]  usedw_o
);

  localparam int DEPTH = 1 << AWIDTH;
  localparam int RAW   = CH_W + AWIDTH;
  localparam flags_t RST_FLG =
    calc_flags(0, DEPTH, ALMOST_FULL, ALMOST_EMPTY);

  typedef logic [AWIDTH:0] cnt_t;

  cnt_t   cnt_q [CHANNELS];
  cnt_t   cnt_d [CHANNELS];
  flags_t flg_d [CHANNELS];

  logic [CHANNELS-1:0] empty_q, aempty_q;
  logic [CHANNELS-1:0] afull_q, full_q;

  logic wr_in, rd_in, wr_clr, rd_clr, same;
  logic pop_acc, push_acc, byp, we, re;
  logic [AWIDTH-1:0] rd_ptr;
  logic [DWIDTH-1:0] ram_q;

  logic              v1_q, sel1_q;
  logic [CH_W-1:0]   ch1_q;
  logic [DWIDTH-1:0] byp1_q;
  logic [DWIDTH-1:0] q_q;
  logic              qv_q;
  logic [CH_W-1:0]   qch_q;

  assign wr_in  = 32'(wr_ch_i) < CHANNELS;
  assign rd_in  = 32'(rd_ch_i) < CHANNELS;
  assign wr_clr = clear_i && (clear_ch_i == wr_ch_i);
  assign rd_clr = clear_i && (clear_ch_i == rd_ch_i);
  assign same   = (wr_ch_i == rd_ch_i);

  // A full channel still takes a push when the
  // same-channel pop frees the slot this cycle.
  assign pop_acc  = rdreq_i && rd_in
                 && !empty_q[rd_ch_i] && !rd_clr;
  assign push_acc = wrreq_i && wr_in && !wr_clr
                 && (!full_q[wr_ch_i]
                     || (pop_acc && same));
  assign byp = push_acc && pop_acc && same;
  assign we  = push_acc && !byp;
  assign re  = pop_acc && !byp;

  assign rd_ptr =
    AWIDTH'(cnt_q[rd_ch_i] - cnt_t'(1));

  mc_lifo_ram #(
    .DWIDTH (DWIDTH),
    .RAW    (RAW),
    .DEPTH  (CHANNELS * DEPTH)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (we),
    .waddr_i ({wr_ch_i,
               cnt_q[wr_ch_i][AWIDTH-1:0]}),
    .wdata_i (data_i),
    .re_i    (re),
    .raddr_i ({rd_ch_i, rd_ptr}),
    .rdata_o (ram_q)
  );

  // next pointer per channel; clear wins
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      cnt_d[c] = cnt_q[c];
      if (we && 32'(wr_ch_i) == c)
        cnt_d[c] = cnt_q[c] + cnt_t'(1);
      if (re && 32'(rd_ch_i) == c)
        cnt_d[c] = cnt_q[c] - cnt_t'(1);
      if (clear_i && 32'(clear_ch_i) == c)
        cnt_d[c] = '0;
      flg_d[c] = calc_flags(32'(cnt_d[c]), DEPTH,
                            ALMOST_FULL,
                            ALMOST_EMPTY);
    end
  end

  // pointer and flag registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < CHANNELS; c++) begin
        cnt_q[c]    <= '0;
        empty_q[c]  <= RST_FLG.empty;
        aempty_q[c] <= RST_FLG.aempty;
        afull_q[c]  <= RST_FLG.afull;
        full_q[c]   <= RST_FLG.full;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        cnt_q[c]    <= cnt_d[c];
        empty_q[c]  <= flg_d[c].empty;
        aempty_q[c] <= flg_d[c].aempty;
        afull_q[c]  <= flg_d[c].afull;
        full_q[c]   <= flg_d[c].full;
      end
    end
  end

  // stage 1: track pop in flight with the RAM read
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v1_q   <= 1'b0;
      sel1_q <= 1'b0;
      ch1_q  <= '0;
      byp1_q <= '0;
    end else begin
      v1_q <= pop_acc;
      if (pop_acc) begin
        sel1_q <= byp;
        ch1_q  <= rd_ch_i;
      end
      if (byp) byp1_q <= data_i;
    end
  end

  // stage 2: output register, holds between pops
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q   <= '0;
      qv_q  <= 1'b0;
      qch_q <= '0;
    end else begin
      qv_q <= v1_q;
      if (v1_q) begin
        q_q   <= sel1_q ? byp1_q : ram_q;
        qch_q <= ch1_q;
      end
    end
  end

  assign q_o            = q_q;
  assign q_valid_o      = qv_q;
  assign q_ch_o         = qch_q;
  assign empty_o        = empty_q;
  assign almost_empty_o = aempty_q;
  assign almost_full_o  = afull_q;
  assign full_o         = full_q;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_uw
    assign usedw_o[g*(AWIDTH+1) +: AWIDTH+1] =
      cnt_q[g];
  end

endmodule

// File: tb/tb_mc_lifo.sv
// Self-checking bench for mc_lifo against a
// per-channel queue model.
module tb_mc_lifo;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int CH = 4;
  localparam int DEPTH = 256;
  localparam int UW = AW + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_ni = 1'b0;
  logic          wrreq_i = 1'b0;
  logic [1:0]    wr_ch_i = '0;
  logic [DW-1:0] data_i = '0;
  logic          rdreq_i = 1'b0;
  logic [1:0]    rd_ch_i = '0;
  logic          clear_i = 1'b0;
  logic [1:0]    clear_ch_i = '0;
  logic [DW-1:0] q_o;
  logic          q_valid_o;
  logic [1:0]    q_ch_o;
  logic [CH-1:0] empty_o, almost_empty_o;
  logic [CH-1:0] almost_full_o, full_o;
  logic [CH*UW-1:0] usedw_o;

  mc_lifo dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .wrreq_i        (wrreq_i),
    .wr_ch_i        (wr_ch_i),
    .data_i         (data_i),
    .rdreq_i        (rdreq_i),
    .rd_ch_i        (rd_ch_i),
    .clear_i        (clear_i),
    .clear_ch_i     (clear_ch_i),
    .q_o            (q_o),
    .q_valid_o      (q_valid_o),
    .q_ch_o         (q_ch_o),
    .empty_o        (empty_o),
    .almost_empty_o (almost_empty_o),
    .almost_full_o  (almost_full_o),
    .full_o         (full_o),
    .usedw_o        (usedw_o)
  );

  int tests_run = 0;
  int fails = 0;

  logic [DW-1:0] mq [CH][$];
  bit            pend_v;
  logic [DW-1:0] pend_q;
  logic [1:0]    pend_ch;
  bit            exp_qv;
  logic [DW-1:0] exp_q;
  logic [1:0]    exp_qch;
  logic [CH*UW-1:0] e_usedw;
  logic [CH-1:0] e_empty, e_ae, e_af, e_full;

  task automatic model_reset();
    for (int c = 0; c < CH; c++) mq[c].delete();
    pend_v  = 0;
    exp_qv  = 0;
    exp_q   = '0;
    exp_qch = '0;
  endtask

  task automatic model_status();
    for (int c = 0; c < CH; c++) begin
      int n = mq[c].size();
      e_usedw[c*UW +: UW] = UW'(n);
      e_empty[c] = (n == 0);
      e_ae[c]    = (n <= 2);
      e_af[c]    = (n >= 2);
      e_full[c]  = (n == DEPTH);
    end
  endtask

  // apply one cycle of requests, advance model,
  // return 1 time unit after the clock edge
  task automatic drive(input bit w, input int wc,
                       input logic [DW-1:0] d,
                       input bit r, input int rc,
                       input bit cl, input int cc);
    bit popok, pushok;
    wrreq_i = w; wr_ch_i = 2'(wc); data_i = d;
    rdreq_i = r; rd_ch_i = 2'(rc);
    clear_i = cl; clear_ch_i = 2'(cc);
    popok  = r && !(cl && cc == rc)
          && mq[rc].size() > 0;
    pushok = w && !(cl && cc == wc)
          && (mq[wc].size() < DEPTH
              || (popok && wc == rc));
    exp_qv = pend_v;
    if (pend_v) begin
      exp_q   = pend_q;
      exp_qch = pend_ch;
    end
    pend_v = popok;
    if (popok) pend_ch = 2'(rc);
    if (popok && pushok && wc == rc) begin
      pend_q = d;
    end else begin
      if (popok) pend_q = mq[rc].pop_back();
      if (pushok) mq[wc].push_back(d);
    end
    if (cl) mq[cc].delete();
    model_status();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, '0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (usedw_o !== '0 || empty_o !== 4'hf
        || almost_empty_o !== 4'hf
        || almost_full_o !== 4'h0
        || full_o !== 4'h0) begin
      fails++;
      $display("FAIL reset_flags: usedw=%h e=%b ae=%b af=%b f=%b want 0 1111 1111 0000 0000",
               usedw_o, empty_o, almost_empty_o,
               almost_full_o, full_o);
    end
    tests_run++;
    if (q_o !== '0 || q_valid_o !== 1'b0
        || q_ch_o !== '0) begin
      fails++;
      $display("FAIL reset_q: q=%h v=%b ch=%0d want 0 0 0",
               q_o, q_valid_o, q_ch_o);
    end
    @(negedge clk);
    rst_ni = 1'b1;
    model_reset();
    model_status();
  endtask

  task automatic test_fill();
    logic [DW-1:0] ref_q [$];
    logic [DW-1:0] d;
    for (int i = 0; i < DEPTH; i++) begin
      d = 16'($urandom);
      ref_q.push_back(d);
      drive(1, 0, d, 0, 0, 0, 0);
    end
    tests_run++;
    if (full_o !== 4'b0001
        || usedw_o[0 +: UW] !== 9'd256
        || almost_full_o[0] !== 1'b1) begin
      fails++;
      $display("FAIL fill_full: full=%b used0=%0d af0=%b want 0001 256 1",
               full_o, usedw_o[0 +: UW],
               almost_full_o[0]);
    end
    for (int i = 0; i < 5; i++)
      drive(1, 0, 16'($urandom), 0, 0, 0, 0);
    tests_run++;
    if (full_o !== 4'b0001
        || usedw_o[0 +: UW] !== 9'd256) begin
      fails++;
      $display("FAIL push_on_full: full=%b used0=%0d want 0001 256",
               full_o, usedw_o[0 +: UW]);
    end
    for (int i = 0; i <= DEPTH; i++) begin
      drive(0, 0, '0, i < DEPTH, 0, 0, 0);
      if (i >= 1) begin
        tests_run++;
        if (q_valid_o !== 1'b1
            || q_o !== ref_q[DEPTH-i]) begin
          fails++;
          $display("FAIL drain pop %0d: v=%b q=%h want 1 %h",
                   i - 1, q_valid_o, q_o,
                   ref_q[DEPTH-i]);
        end
      end
    end
    tests_run++;
    if (empty_o !== 4'hf || usedw_o !== '0) begin
      fails++;
      $display("FAIL drain_empty: empty=%b usedw=%h want 1111 0",
               empty_o, usedw_o);
    end
  endtask

  task automatic test_empty_pop();
    logic [DW-1:0] q0;
    q0 = q_o;
    for (int i = 0; i < 32; i++) begin
      drive(0, 0, '0, 1, 2, 0, 0);
      tests_run++;
      if (q_valid_o !== 1'b0 || q_o !== q0
          || usedw_o !== '0) begin
        fails++;
        $display("FAIL empty_pop %0d: v=%b q=%h usedw=%h want 0 %h 0",
                 i, q_valid_o, q_o, usedw_o, q0);
      end
    end
  endtask

  task automatic test_interleave();
    logic [DW-1:0] w;
    int idx;
    int ch;
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, 16'(16'hA000 + i), 0, 0, 0, 0);
      drive(1, 3, 16'(16'hB000 + i), 0, 0, 0, 0);
    end
    for (int k = 0; k <= 20; k++) begin
      drive(0, 0, '0, k < 20, (k % 2) ? 3 : 1, 0, 0);
      if (k >= 1) begin
        idx = 9 - (k - 1) / 2;
        ch  = ((k - 1) % 2) ? 3 : 1;
        w   = (ch == 1) ? 16'(16'hA000 + idx)
                        : 16'(16'hB000 + idx);
        tests_run++;
        if (q_valid_o !== 1'b1 || q_o !== w
            || q_ch_o !== 2'(ch)) begin
          fails++;
          $display("FAIL interleave %0d: v=%b q=%h ch=%0d want 1 %h %0d",
                   k - 1, q_valid_o, q_o, q_ch_o, w, ch);
        end
      end
    end
  endtask

  task automatic test_bypass();
    logic [DW-1:0] d, prevd;
    prevd = '0;
    for (int i = 0; i < 128; i++)
      drive(1, 0, 16'($urandom), 0, 0, 0, 0);
    for (int i = 0; i <= 100; i++) begin
      d = 16'($urandom);
      drive(i < 100, 0, d, i < 100, 0, 0, 0);
      if (i >= 1) begin
        tests_run++;
        if (q_valid_o !== 1'b1 || q_o !== prevd
            || usedw_o[0 +: UW] !== 9'd128) begin
          fails++;
          $display("FAIL bypass %0d: v=%b q=%h used0=%0d want 1 %h 128",
                   i - 1, q_valid_o, q_o,
                   usedw_o[0 +: UW], prevd);
        end
      end
      prevd = d;
    end
  endtask

  task automatic test_clear();
    logic [DW-1:0] w;
    for (int i = 0; i < 10; i++)
      drive(1, 2, 16'($urandom), 0, 0, 0, 0);
    drive(0, 0, '0, 1, 2, 1, 2);
    tests_run++;
    if (usedw_o[2*UW +: UW] !== '0
        || empty_o[2] !== 1'b1) begin
      fails++;
      $display("FAIL clear_used: used2=%0d e2=%b want 0 1",
               usedw_o[2*UW +: UW], empty_o[2]);
    end
    idle();
    tests_run++;
    if (q_valid_o !== 1'b0) begin
      fails++;
      $display("FAIL clear_pop_valid: v=%b want 0",
               q_valid_o);
    end
    drive(1, 2, 16'h0111, 0, 0, 0, 0);
    drive(1, 2, 16'h0222, 0, 0, 0, 0);
    drive(1, 2, 16'h0333, 0, 0, 0, 0);
    for (int k = 0; k <= 3; k++) begin
      drive(0, 0, '0, k < 3, 2, 0, 0);
      if (k >= 1) begin
        w = (k == 1) ? 16'h0333
          : (k == 2) ? 16'h0222 : 16'h0111;
        tests_run++;
        if (q_valid_o !== 1'b1 || q_o !== w
            || q_ch_o !== 2'd2) begin
          fails++;
          $display("FAIL clear_refill %0d: v=%b q=%h ch=%0d want 1 %h 2",
                   k, q_valid_o, q_o, q_ch_o, w);
        end
      end
    end
  endtask

  task automatic test_random();
    bit w, r, cl;
    int wc, rc, cc, pw, pr;
    int nbad;
    nbad = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i >= 400 && i < 1100) begin
        pw = 90; pr = 20;
        wc = $urandom_range(0, 1);
        rc = $urandom_range(0, 1);
      end else begin
        pw = 55; pr = 50;
        wc = $urandom_range(0, 3);
        rc = $urandom_range(0, 3);
      end
      w  = $urandom_range(0, 99) < pw;
      r  = $urandom_range(0, 99) < pr;
      cl = $urandom_range(0, 99) < 2;
      cc = $urandom_range(0, 3);
      drive(w, wc, 16'($urandom), r, rc, cl, cc);
      tests_run++;
      if (q_valid_o !== exp_qv || q_o !== exp_q
          || q_ch_o !== exp_qch
          || usedw_o !== e_usedw
          || empty_o !== e_empty
          || almost_empty_o !== e_ae
          || almost_full_o !== e_af
          || full_o !== e_full) begin
        fails++;
        nbad++;
        if (nbad <= 10)
          $display("FAIL random %0d: v=%b q=%h ch=%0d used=%h f=%b%b%b%b want %b %h %0d %h %b%b%b%b",
                   i, q_valid_o, q_o, q_ch_o, usedw_o,
                   empty_o, almost_empty_o,
                   almost_full_o, full_o,
                   exp_qv, exp_q, exp_qch, e_usedw,
                   e_empty, e_ae, e_af, e_full);
      end
      if (i == 1500) begin
        wrreq_i = 0; rdreq_i = 0; clear_i = 0;
        #2;
        rst_ni = 1'b0;
        #1;
        model_reset();
        model_status();
        tests_run++;
        if (q_valid_o !== 1'b0 || q_o !== '0
            || usedw_o !== '0 || empty_o !== 4'hf
            || full_o !== 4'h0) begin
          fails++;
          $display("FAIL mid_reset: v=%b q=%h used=%h e=%b f=%b want 0 0 0 1111 0000",
                   q_valid_o, q_o, usedw_o,
                   empty_o, full_o);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
      end
    end
  endtask

  initial begin
    model_reset();
    model_status();
    test_reset();
    test_fill();
    test_empty_pop();
    test_interleave();
    test_bypass();
    test_clear();
    test_random();
    $display("[TB] %0d tests run, %0d failed",
             tests_run, fails);
    $finish;
  end

endmodule
